subterranean_stream_driver: RTL

//  Host-side end of the subterranean_stream protocol. Takes commands plus byte messages, and drives inst then din
//  (32-bit words, byte 0 in [7:0], din_size 0..4, din_last). Unpacks the dout words back into bytes.

---
 rtl/subterranean_stream_driver_pkg.sv | 24 ++
 rtl/subterranean_stream_unpacker.sv | 73 +++++++
 rtl/subterranean_stream_driver.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/subterranean_stream_driver_pkg.sv
// Shared types and constants for the subterranean_stream host driver.
// TX state encodings, cmd_mode values and din_size bounds.
package subterranean_stream_driver_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_INST = 2'd1,
    TX_PACK = 2'd2,
    TX_SEND = 2'd3
  } tx_state_t;

  localparam logic [1:0] MODE_NONE   = 2'b00;
  localparam logic [1:0] MODE_EMPTY  = 2'b01;
  localparam logic [1:0] MODE_STREAM = 2'b10;

  localparam logic [2:0] SIZE_EMPTY = 3'd0;
  localparam logic [2:0] SIZE_FULL  = 3'd4;

  // The core can report sizes up to 7; anything past a full word is a full word.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > SIZE_FULL) ? SIZE_FULL : size;
  endfunction

endpackage

// File: rtl/subterranean_stream_unpacker.sv
// RX path: accepts dout words from the core and replays them as a byte stream,
// lowest lane first, pulsing rx_done once a dout_last word is fully delivered.
module subterranean_stream_unpacker
  import subterranean_stream_driver_pkg::*;
(
  input  logic        clk,
  input  logic        arstn,
  input  logic        flush,
  input  logic [31:0] dout,
  input  logic [2:0]  dout_size,
  input  logic        dout_last,
  input  logic        dout_valid,
  output logic        dout_ready,
  output logic [7:0]  m_byte,
  output logic        m_byte_last,
  output logic        m_byte_valid,
  input  logic        m_byte_ready,
  output logic        rx_done,
  output logic        rx_busy
);

  logic [31:0] word_reg;
  logic [2:0]  cnt_reg;
  logic        last_reg;
  logic        done_reg;
  logic        en_reg;
  logic [2:0]  size_in;
  logic        byte_hs;
  logic        final_take;
  logic        dout_hs;

  assign size_in      = clamp_size(dout_size);
  assign m_byte_valid = (cnt_reg != SIZE_EMPTY);
  assign m_byte       = word_reg[7:0];
  assign m_byte_last  = last_reg && (cnt_reg == 3'd1);
  assign byte_hs      = m_byte_valid && m_byte_ready;
  assign final_take   = byte_hs && (cnt_reg == 3'd1);
  // Accepting while the last byte leaves keeps consecutive words gap-free.
  assign dout_ready   = en_reg && !flush && (!m_byte_valid || final_take);
  assign dout_hs      = dout_valid && dout_ready;
  assign rx_done      = done_reg;
  assign rx_busy      = m_byte_valid;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      word_reg <= '0;
      cnt_reg  <= SIZE_EMPTY;
      last_reg <= 1'b0;
      done_reg <= 1'b0;
      en_reg   <= 1'b0;
    end else begin
      en_reg   <= 1'b1;
      done_reg <= 1'b0;
      if (flush) begin
        word_reg <= '0;
        cnt_reg  <= SIZE_EMPTY;
        last_reg <= 1'b0;
      end else begin
        done_reg <= (final_take && last_reg) ||
                    (dout_hs && (size_in == SIZE_EMPTY) && dout_last);
        if (dout_hs) begin
          word_reg <= dout;
          cnt_reg  <= size_in;
          last_reg <= dout_last;
        end else if (byte_hs) begin
          word_reg <= {8'h00, word_reg[31:8]};
          cnt_reg  <= cnt_reg - 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/subterranean_stream_driver.sv
// Host-side driver: issues inst, packs host bytes into din words, unpacks dout.
// Optional idle-handshake watchdog: SUBTERRANEAN_STREAM_DRIVER_WATCHDOG_EN.
module subterranean_stream_driver
  import subterranean_stream_driver_pkg::*;
#(
  parameter int G_WATCHDOG_CYCLES = 1024
)
(
  input  logic        clk,
  input  logic        arstn,
  input  logic [3:0]  cmd_inst,
  input  logic [1:0]  cmd_mode,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  s_byte,
  input  logic        s_byte_last,
  input  logic        s_byte_valid,
  output logic        s_byte_ready,
  output logic [7:0]  m_byte,
  output logic        m_byte_last,
  output logic        m_byte_valid,
  input  logic        m_byte_ready,
  output logic        rx_done,
  output logic [3:0]  inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] din,
  output logic [2:0]  din_size,
  output logic        din_last,
  output logic        din_valid,
  input  logic        din_ready,
  input  logic [31:0] dout,
  input  logic [2:0]  dout_size,
  input  logic        dout_last,
  input  logic        dout_valid,
  output logic        dout_ready,
  output logic        busy,
  output logic        error
);

  tx_state_t   state_reg;
  logic        cmd_ready_reg;
  logic        inst_valid_reg;
  logic        s_byte_ready_reg;
  logic        din_valid_reg;
  logic [3:0]  inst_reg;
  logic [1:0]  mode_reg;
  logic [31:0] pack_reg;
  logic [2:0]  cnt_reg;
  logic        last_reg;
  logic        rx_busy;
  logic        wd_fire;
  logic        cmd_hs;
  logic        inst_hs;
  logic        byte_hs;
  logic        din_hs;

  assign cmd_hs  = cmd_valid && cmd_ready_reg;
  assign inst_hs = inst_valid_reg && inst_ready;
  assign byte_hs = s_byte_valid && s_byte_ready_reg;
  assign din_hs  = din_valid_reg && din_ready;

  assign cmd_ready    = cmd_ready_reg;
  assign inst         = inst_reg;
  assign inst_valid   = inst_valid_reg;
  assign s_byte_ready = s_byte_ready_reg;
  assign din          = pack_reg;
  assign din_size     = cnt_reg;
  assign din_last     = last_reg;
  assign din_valid    = din_valid_reg;
  assign busy         = (state_reg != TX_IDLE) || rx_busy;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_reg        <= TX_IDLE;
      cmd_ready_reg    <= 1'b0;
      inst_valid_reg   <= 1'b0;
      s_byte_ready_reg <= 1'b0;
      din_valid_reg    <= 1'b0;
      inst_reg         <= '0;
      mode_reg         <= MODE_NONE;
      pack_reg         <= '0;
      cnt_reg          <= SIZE_EMPTY;
      last_reg         <= 1'b0;
    end else if (wd_fire) begin
      state_reg        <= TX_IDLE;
      cmd_ready_reg    <= 1'b1;
      inst_valid_reg   <= 1'b0;
      s_byte_ready_reg <= 1'b0;
      din_valid_reg    <= 1'b0;
      pack_reg         <= '0;
      cnt_reg          <= SIZE_EMPTY;
      last_reg         <= 1'b0;
    end else begin
      case (state_reg)
        TX_IDLE: begin
          cmd_ready_reg <= 1'b1;
          if (cmd_hs) begin
            inst_reg       <= cmd_inst;
            mode_reg       <= cmd_mode;
            cmd_ready_reg  <= 1'b0;
            inst_valid_reg <= 1'b1;
            state_reg      <= TX_INST;
          end
        end
        TX_INST: begin
          if (inst_hs) begin
            inst_valid_reg <= 1'b0;
            case (mode_reg)
              MODE_EMPTY: begin
                pack_reg      <= '0;
                cnt_reg       <= SIZE_EMPTY;
                last_reg      <= 1'b1;
                din_valid_reg <= 1'b1;
                state_reg     <= TX_SEND;
              end
              MODE_STREAM: begin
                cnt_reg          <= SIZE_EMPTY;
                last_reg         <= 1'b0;
                s_byte_ready_reg <= 1'b1;
                state_reg        <= TX_PACK;
              end
              // Mode 11 behaves like 00: instruction only.
              default: begin
                cmd_ready_reg <= 1'b1;
                state_reg     <= TX_IDLE;
              end
            endcase
          end
        end
        TX_PACK: begin
          if (byte_hs) begin
            pack_reg[{cnt_reg[1:0], 3'b000} +: 8] <= s_byte;
            cnt_reg <= cnt_reg + 3'd1;
            if ((cnt_reg == 3'd3) || s_byte_last) begin
              s_byte_ready_reg <= 1'b0;
              last_reg         <= s_byte_last;
              din_valid_reg    <= 1'b1;
              state_reg        <= TX_SEND;
            end
          end
        end
        TX_SEND: begin
          if (din_hs) begin
            din_valid_reg <= 1'b0;
            cnt_reg       <= SIZE_EMPTY;
            pack_reg      <= '0;
            if (last_reg) begin
              last_reg      <= 1'b0;
              cmd_ready_reg <= 1'b1;
              state_reg     <= TX_IDLE;
            end else begin
              s_byte_ready_reg <= 1'b1;
              state_reg        <= TX_PACK;
            end
          end
        end
        default: state_reg <= TX_IDLE;
      endcase
    end
  end

`ifdef SUBTERRANEAN_STREAM_DRIVER_WATCHDOG_EN
  logic [31:0] wd_cnt_reg;
  logic        error_reg;
  logic        any_hs;

  assign any_hs  = cmd_hs || inst_hs || byte_hs || din_hs ||
                   (dout_valid && dout_ready) || (m_byte_valid && m_byte_ready);
  assign wd_fire = (wd_cnt_reg == 32'(G_WATCHDOG_CYCLES - 1));
  assign error   = error_reg;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wd_cnt_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      if (cmd_hs)
        error_reg <= 1'b0;
      if (wd_fire) begin
        error_reg  <= 1'b1;
        wd_cnt_reg <= '0;
      end else if (any_hs || !busy) begin
        wd_cnt_reg <= '0;
      end else begin
        wd_cnt_reg <= wd_cnt_reg + 32'd1;
      end
    end
  end
`else
  assign wd_fire = 1'b0;
  assign error   = 1'b0;
`endif

  subterranean_stream_unpacker u_unpacker (
    .clk          (clk),
    .arstn        (arstn),
    .flush        (wd_fire),
    .dout         (dout),
    .dout_size    (dout_size),
    .dout_last    (dout_last),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .m_byte       (m_byte),
    .m_byte_last  (m_byte_last),
    .m_byte_valid (m_byte_valid),
    .m_byte_ready (m_byte_ready),
    .rx_done      (rx_done),
    .rx_busy      (rx_busy)
  );

endmodule
